// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin arbiter/sequencer sharing one AES-128 core
// between two requesters, with a watchdog that turns a hung core into an
// error response.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   reqN_valid/ready      request handshake (N = 0,1); ready only in IDLE
//   reqN_key/reqN_data    key and plaintext, read only on the handshake cycle
//   rspN_valid/ready      response handshake for the granted requester
//   rspN_data/rspN_err    ciphertext (0 on error) and timeout flag
//   core_start            one-cycle launch pulse to the AES core
//   core_key/core_data    registered job operands to the core
//   core_done/result      completion pulse and ciphertext from the core
//   busy                  high whenever the FSM is not IDLE
module aes_req_arbiter #(
    parameter int KEY_LENGTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [KEY_LENGTH-1:0] req0_key,
    input  logic [127:0]          req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [KEY_LENGTH-1:0] req1_key,
    input  logic [127:0]          req1_data,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [127:0]          rsp0_data,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [127:0]          rsp1_data,
    output logic                  rsp1_err,
    output logic                  core_start,
    output logic [KEY_LENGTH-1:0] core_key,
    output logic [127:0]          core_data,
    input  logic                  core_done,
    input  logic [127:0]          core_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state;
    logic           last_grant;
    logic           grant;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           timeout;
    logic [127:0]   rsp_data;
    logic           rsp_err;
    logic           pick1;
    logic           take;
    logic           rsp_take;

    // req1 wins when it is alone, or when both ask and req0 went last.
    assign pick1 = req1_valid & (~req0_valid | ~last_grant);
    assign take  = (state == IDLE) & (req0_valid | req1_valid);

    assign req0_ready = (state == IDLE) & req0_valid & ~pick1;
    assign req1_ready = (state == IDLE) & pick1;
    assign busy       = (state != IDLE);

    // The counter value after this cycle's increment decides the timeout,
    // so WAIT is left S+TIMEOUT_CYCLES-1 cycles after core_start at S.
    assign cnt_next = cnt + CW'(1);
    assign timeout  = (cnt_next == CW'(TIMEOUT_CYCLES - 1));

    assign rsp_take = grant ? rsp1_ready : rsp0_ready;

    assign rsp0_data = rsp0_valid ? rsp_data : '0;
    assign rsp1_data = rsp1_valid ? rsp_data : '0;
    assign rsp0_err  = rsp0_valid & rsp_err;
    assign rsp1_err  = rsp1_valid & rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= '0;
            core_start <= 1'b0;
            core_key   <= '0;
            core_data  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        core_key   <= pick1 ? req1_key : req0_key;
                        core_data  <= pick1 ? req1_data : req0_data;
                        grant      <= pick1;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_next;
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        rsp_data   <= core_result;
                        rsp_err    <= 1'b0;
                        rsp0_valid <= ~grant;
                        rsp1_valid <= grant;
                        state      <= RESP;
                    end else if (timeout) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        rsp0_valid <= ~grant;
                        rsp1_valid <= grant;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rsp_err    <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
